// File: rtl/fifo_skew_reader.sv
// Read-side sequencer for fifo_array: issues diagonally skewed per-lane reads so
// lane i starts i cycles after lane 0, stalling the whole wavefront on any empty lane.
module fifo_skew_reader #(
  parameter int data_size  = 8,
  parameter int array_size = 9,
  parameter int row_len    = 9,
  parameter int cnt_width  = 5
) (
  input  logic                            clk,
  input  logic                            clear,
  input  logic                            start,
  input  logic [array_size-1:0]           empty,
  input  logic [data_size*array_size-1:0] fifo_data,
  output logic [array_size-1:0]           r_en,
  output logic [data_size*array_size-1:0] out_data,
  output logic [array_size-1:0]           out_valid,
  output logic                            out_step,
  output logic                            busy,
  output logic                            done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [cnt_width-1:0] last_t = cnt_width'(row_len + array_size - 2);
  localparam logic [cnt_width-1:0] one_t  = cnt_width'(1);

  state_t                  state_r;
  logic [cnt_width-1:0]    t_r;
  logic [array_size-1:0]   out_valid_r;
  logic                    out_step_r;
  logic                    busy_r;
  logic                    done_r;

  logic [array_size-1:0]   sched_s;
  logic                    adv_s;
  logic [array_size-1:0]   r_en_s;
  logic [data_size*array_size-1:0] out_data_s;

  // Lane is inside its row_len-long read window, offset by its lane index.
  function automatic logic lane_sched(input logic [cnt_width-1:0] t, input int lane);
    logic [cnt_width-1:0] lo;
    logic [cnt_width-1:0] hi;
    lo = cnt_width'(lane);
    hi = cnt_width'(lane + row_len);
    return (t >= lo) && (t < hi);
  endfunction

  // Schedule, stall detection and read enables; a stall freezes every lane together.
  always_comb begin
    sched_s = '0;
    for (int i = 0; i < array_size; i++) begin
      sched_s[i] = (state_r == ST_RUN) && lane_sched(t_r, i);
    end
    adv_s = &(~sched_s | ~empty);
    if (adv_s) begin
      r_en_s = sched_s;
    end else begin
      r_en_s = '0;
    end
  end

  // Zero-fill lanes whose FIFO word is not valid this cycle.
  always_comb begin
    out_data_s = '0;
    for (int i = 0; i < array_size; i++) begin
      if (out_valid_r[i]) begin
        out_data_s[i*data_size +: data_size] = fifo_data[i*data_size +: data_size];
      end else begin
        out_data_s[i*data_size +: data_size] = {data_size{1'b0}};
      end
    end
  end

  // Pass sequencer with registered status and output-stage flags.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_r     <= ST_IDLE;
      t_r         <= '0;
      out_valid_r <= '0;
      out_step_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      out_valid_r <= r_en_s;
      out_step_r  <= adv_s & (state_r == ST_RUN);
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r <= ST_RUN;
            t_r     <= '0;
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        ST_RUN: begin
          // Leaving on the final wavefront keeps the last read one cycle from DRAIN.
          if (adv_s) begin
            t_r <= t_r + one_t;
            if (t_r == last_t) begin
              state_r <= ST_DRAIN;
            end else begin
              state_r <= ST_RUN;
            end
          end else begin
            t_r <= t_r;
          end
        end
        ST_DRAIN: begin
          state_r <= ST_DONE;
          done_r  <= 1'b1;
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          t_r     <= '0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign r_en      = r_en_s;
  assign out_data  = out_data_s;
  assign out_valid = out_valid_r;
  assign out_step  = out_step_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_fifo_skew_reader.sv
// Randomized bench for fifo_skew_reader against a wavefront-level reference model,
// plus a directed run of the array_size=2,row_len=1 corner configuration.
module tb_fifo_skew_reader;
  localparam int DW = 8;
  localparam int AS = 9;
  localparam int RL = 9;
  localparam int CW = 5;
  localparam int LW = RL + AS - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                clear;
  logic                start;
  logic [AS-1:0]       empty;
  logic [DW*AS-1:0]    fifo_data;
  logic [AS-1:0]       r_en;
  logic [DW*AS-1:0]    out_data;
  logic [AS-1:0]       out_valid;
  logic                out_step;
  logic                busy;
  logic                done;

  logic                s_start;
  logic [1:0]          s_ren;
  logic [15:0]         s_odata;
  logic [1:0]          s_ovalid;
  logic                s_step;
  logic                s_busy;
  logic                s_done;

  fifo_skew_reader #(.data_size(DW), .array_size(AS), .row_len(RL), .cnt_width(CW)) dut (
    .clk(clk), .clear(clear), .start(start), .empty(empty), .fifo_data(fifo_data),
    .r_en(r_en), .out_data(out_data), .out_valid(out_valid), .out_step(out_step),
    .busy(busy), .done(done)
  );

  fifo_skew_reader #(.data_size(8), .array_size(2), .row_len(1), .cnt_width(5)) dut_small (
    .clk(clk), .clear(clear), .start(s_start), .empty(2'b00), .fifo_data(16'h0000),
    .r_en(s_ren), .out_data(s_odata), .out_valid(s_ovalid), .out_step(s_step),
    .busy(s_busy), .done(s_done)
  );

  int n_cmp = 0;
  int n_err = 0;

  // bench FIFO contents
  logic [DW-1:0] mem [AS][RL];
  int rd_ptr [AS];
  int wr_cnt [AS];

  // reference model: wavefront index, tail phase after the last wavefront
  bit            m_busy;
  int            m_w;
  int            m_tail;
  logic [AS-1:0] m_prev_ren;
  bit            m_prev_step;
  int            m_reads [AS];

  task automatic check_val(input string tag, input logic [71:0] obs, input logic [71:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic bit in_window(int w, int i);
    return (w >= i) && (w < i + RL);
  endfunction

  task automatic preload();
    for (int i = 0; i < AS; i++) begin
      for (int k = 0; k < RL; k++) mem[i][k] = DW'(16*i + k);
      rd_ptr[i]  = 0;
      wr_cnt[i]  = RL;
      m_reads[i] = 0;
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_w = 0; m_tail = 0; m_prev_ren = '0; m_prev_step = 1'b0;
  endtask

  // Entered at posedge+1; drives inputs, checks the cycle, then crosses the next edge.
  task automatic step_cycle(input logic [AS-1:0] force_e, input logic st);
    logic [AS-1:0]    fe;
    logic [AS-1:0]    win;
    logic [AS-1:0]    xren;
    logic [AS-1:0]    ren_seen;
    logic [DW*AS-1:0] xdata;
    bit               run;
    bit               stall;
    fe = '0;
    for (int i = 0; i < AS; i++) fe[i] = (rd_ptr[i] >= wr_cnt[i]);
    start = st;
    empty = fe | force_e;
    #1;
    run = m_busy && (m_w < LW);
    win = '0;
    for (int i = 0; i < AS; i++) win[i] = run && in_window(m_w, i);
    stall = (win & empty) != '0;
    xren  = stall ? '0 : win;
    xdata = '0;
    for (int i = 0; i < AS; i++)
      if (m_prev_ren[i]) xdata[i*DW +: DW] = DW'(16*i + m_reads[i] - 1);
    check_val("r_en", 72'(r_en), 72'(xren));
    check_val("out_valid", 72'(out_valid), 72'(m_prev_ren));
    check_val("out_step", 72'(out_step), 72'(m_prev_step));
    check_val("busy", 72'(busy), 72'(m_busy));
    check_val("done", 72'(done), 72'(m_busy && m_w == LW && m_tail == 1));
    check_val("out_data", 72'(out_data), 72'(xdata));
    ren_seen = r_en;
    if (!m_busy) begin
      if (st) begin m_busy = 1'b1; m_w = 0; m_tail = 0; end
    end else if (run) begin
      if (!stall) m_w++;
    end else if (m_tail == 0) begin
      m_tail = 1;
    end else begin
      m_busy = 1'b0;
    end
    m_prev_ren  = xren;
    m_prev_step = run && !stall;
    for (int i = 0; i < AS; i++) if (xren[i]) m_reads[i]++;
    @(posedge clk);
    for (int i = 0; i < AS; i++) begin
      if (ren_seen[i]) begin
        if (rd_ptr[i] >= wr_cnt[i]) begin
          check_val("underflow", 72'(1), 72'(0));
        end else begin
          fifo_data[i*DW +: DW] = mem[i][rd_ptr[i]];
          rd_ptr[i]++;
        end
      end
    end
    #1;
    start = 1'b0;
  endtask

  // mode 0: clean, 1: lane 3 empty at wavefront 5 for 4 cycles, 2: random stalls/starts
  task automatic run_pass(input int mode);
    logic [AS-1:0] f;
    bit            fired;
    int            stall_left;
    fired = 1'b0;
    stall_left = 0;
    preload();
    step_cycle('0, 1'b1);
    for (int c = 0; c < 120 && m_busy; c++) begin
      f = '0;
      if (mode == 1) begin
        if (!fired && m_w == 5) begin fired = 1'b1; stall_left = 4; end
        if (stall_left > 0) begin f[3] = 1'b1; stall_left--; end
        step_cycle(f, 1'b0);
      end else if (mode == 2) begin
        if ($urandom_range(0, 4) == 0) f[$urandom_range(0, AS-1)] = 1'b1;
        step_cycle(f, 1'(($urandom_range(0, 5) == 0) ? 1 : 0));
      end else begin
        step_cycle('0, 1'b0);
      end
    end
    check_val("pass_end", 72'(m_busy), 72'(0));
    for (int i = 0; i < AS; i++) check_val("lane_reads", 72'(rd_ptr[i]), 72'(RL));
  endtask

  initial begin
    clear = 1'b1; start = 1'b0; s_start = 1'b0; empty = '1; fifo_data = '0;
    model_reset();
    preload();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_r_en", 72'(r_en), 72'(0));
    check_val("rst_out_valid", 72'(out_valid), 72'(0));
    check_val("rst_out_step", 72'(out_step), 72'(0));
    check_val("rst_busy", 72'(busy), 72'(0));
    check_val("rst_done", 72'(done), 72'(0));
    check_val("rst_out_data", 72'(out_data), 72'(0));
    check_val("rst_small_busy", 72'(s_busy), 72'(0));
    @(negedge clk); clear = 1'b0;
    @(posedge clk); #1;

    run_pass(0);
    step_cycle('0, 1'b0);
    run_pass(1);
    for (int p = 0; p < 3; p++) run_pass(2);

    // abort mid-pass with clear, then run a clean pass
    preload();
    step_cycle('0, 1'b1);
    for (int c = 0; c < 40 && m_w != 4; c++) step_cycle('0, 1'b0);
    clear = 1'b1;
    #1;
    check_val("clr_r_en", 72'(r_en), 72'(0));
    check_val("clr_out_valid", 72'(out_valid), 72'(0));
    check_val("clr_out_step", 72'(out_step), 72'(0));
    check_val("clr_busy", 72'(busy), 72'(0));
    check_val("clr_done", 72'(done), 72'(0));
    check_val("clr_out_data", 72'(out_data), 72'(0));
    model_reset();
    @(negedge clk); clear = 1'b0;
    @(posedge clk); #1;
    run_pass(0);

    // array_size=2, row_len=1 corner
    s_start = 1'b1; #1;
    check_val("sm_idle_ren", 72'(s_ren), 72'(0));
    @(posedge clk); #1; s_start = 1'b0; #1;
    check_val("sm_c1_ren", 72'(s_ren), 72'(2'b01));
    check_val("sm_c1_busy", 72'(s_busy), 72'(1));
    @(posedge clk); #2;
    check_val("sm_c2_ren", 72'(s_ren), 72'(2'b10));
    check_val("sm_c2_valid", 72'(s_ovalid), 72'(2'b01));
    check_val("sm_c2_step", 72'(s_step), 72'(1));
    @(posedge clk); #2;
    check_val("sm_c3_ren", 72'(s_ren), 72'(0));
    check_val("sm_c3_valid", 72'(s_ovalid), 72'(2'b10));
    check_val("sm_c3_done", 72'(s_done), 72'(0));
    @(posedge clk); #2;
    check_val("sm_c4_done", 72'(s_done), 72'(1));
    check_val("sm_c4_step", 72'(s_step), 72'(0));
    check_val("sm_c4_data", 72'(s_odata), 72'(0));
    @(posedge clk); #2;
    check_val("sm_c5_done", 72'(s_done), 72'(0));
    check_val("sm_c5_busy", 72'(s_busy), 72'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
